// File: rtl/id_pkg.sv
// Shared definitions for the identifier character path: transmitter FSM
// encoding, ASCII class bounds used by the recognizer, default terminator.
package id_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    TAIL = 2'b10,
    FIN  = 2'b11
  } state_t;

  // ASCII class bounds (inclusive) shared with the recognizer side
  localparam logic [7:0] DIGIT_LO = 8'd48;
  localparam logic [7:0] DIGIT_HI = 8'd57;
  localparam logic [7:0] UPPER_LO = 8'd65;
  localparam logic [7:0] UPPER_HI = 8'd90;
  localparam logic [7:0] LOWER_LO = 8'd97;
  localparam logic [7:0] LOWER_HI = 8'd122;

  // Character appended after every transmitted string (space)
  localparam logic [7:0] DEFAULT_TERM = 8'h20;

endpackage

// File: rtl/id_char_tx_if.sv
// Character stream between the transmitter (master) and a sink (slave).
// Handshake: a beat transfers on a rising clk edge where char_valid and
// char_ready are both 1. Once char_valid is raised, char_out and char_valid
// stay unchanged until that transfer happens; char_ready may change freely.
interface id_char_tx_if;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_out, output char_valid, input char_ready);
  modport slave  (input char_out, input char_valid, output char_ready);
endinterface

// File: rtl/id_char_buf.sv
// DEPTH x 8 character store: synchronous write, combinational read.
// Contents are intentionally not reset; len in the parent says what is valid.
module id_char_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port: one character per cycle when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/id_char_tx.sv
// Character-stream transmitter: host loads a string while idle, pulses start,
// and the block emits each character under valid/ready followed by TERM,
// then pulses done for one cycle. Buffer and len survive transmission so a
// second start resends the same string.
module id_char_tx
  import id_pkg::*;
#(
  parameter int         DEPTH = 16,
  parameter logic [7:0] TERM  = DEFAULT_TERM,
  parameter int         LW    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_char,
  input  logic              clear,
  input  logic              start,
  id_char_tx_if.master      stream,
  output logic              busy,
  output logic              done,
  output logic [LW-1:0]     len,
  output logic              overflow,
  output state_t            state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LEN_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] ONE      = LW'(1);

  state_t        state_q, state_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          buf_we;
  logic [7:0]    rd_char;

  id_char_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (len_q[AW-1:0]),
    .wdata (wr_char),
    .raddr (idx_q[AW-1:0]),
    .rdata (rd_char)
  );

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: host commands only matter in IDLE (clear > start > wr_en);
  // while streaming, len and overflow are frozen and only char_ready advances
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    buf_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          len_d = '0;
          ovf_d = 1'b0;
        end else if (start) begin
          idx_d   = '0;
          state_d = (len_q != '0) ? SEND : TAIL;
        end else if (wr_en) begin
          if (len_q < LEN_FULL) begin
            buf_we = 1'b1;
            len_d  = len_q + ONE;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      SEND: begin
        // len > 0 is guaranteed here, so len-1 cannot wrap
        if (stream.char_ready) begin
          if (idx_q == len_q - ONE) begin
            state_d = TAIL;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      TAIL: begin
        if (stream.char_ready) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only (no path from char_ready)
  always_comb begin
    stream.char_out   = 8'h00;
    stream.char_valid = 1'b0;
    done              = 1'b0;
    case (state_q)
      SEND: begin
        stream.char_valid = 1'b1;
        stream.char_out   = rd_char;
      end
      TAIL: begin
        stream.char_valid = 1'b1;
        stream.char_out   = TERM;
      end
      FIN: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign len       = len_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_id_char_tx.sv
// Bench for id_char_tx: a scoreboard queue is filled with the expected
// character stream whenever start is driven, and a negedge monitor pops and
// compares every accepted beat. Scenario tasks add inline checks for timing,
// hold behaviour, counters and reset.
module tb_id_char_tx;
  import id_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = 5;
  localparam logic [7:0] TERM_CH = 8'h20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_char = 8'h00;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [LW-1:0] len;
  logic          overflow;
  state_t        state_dbg;

  id_char_tx_if stream ();

  id_char_tx #(.DEPTH(DEPTH), .TERM(TERM_CH), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_char   (wr_char),
    .clear     (clear),
    .start     (start),
    .stream    (stream),
    .busy      (busy),
    .done      (done),
    .len       (len),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // Clock and global watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected end of tests");
    $fatal(1, "watchdog expired");
  end

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_buf[$];
  logic [7:0] mon_exp;

  // Scoreboard monitor: every accepted beat must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && stream.char_valid && stream.char_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra_beat: got char_out=%h, expected no beat", stream.char_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (stream.char_out !== mon_exp) begin
          failures++;
          $display("FAIL sb_char: got char_out=%h, expected %h", stream.char_out, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_char(input logic [7:0] c);
    wr_en   = 1'b1;
    wr_char = c;
    tick();
    wr_en = 1'b0;
    if (model_buf.size() < DEPTH) model_buf.push_back(c);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_buf.delete();
  endtask

  // Pushes the expected stream; returns one cycle after start is sampled
  task automatic do_start();
    foreach (model_buf[i]) exp_q.push_back(model_buf[i]);
    exp_q.push_back(TERM_CH);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits for done, then one more cycle so the FSM is back in IDLE
  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done pulse", budget);
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d unsent chars, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    checks++;
    if (stream.char_valid !== 1'b0 || stream.char_out !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b out=%h done=%b busy=%b, expected 0 00 0 0",
               stream.char_valid, stream.char_out, done, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (len !== '0 || overflow !== 1'b0 || state_dbg !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got len=%0d ovf=%b state=%0d, expected 0 0 0", len, overflow, state_dbg);
    end
  endtask

  task automatic test_basic_a1();
    stream.char_ready = 1'b1;
    load_char(8'h61);
    load_char(8'h31);
    checks++;
    if (len !== 5'd2) begin
      failures++;
      $display("FAIL a1_len: got %0d, expected 2", len);
    end
    do_start();
    checks++;
    if (stream.char_valid !== 1'b1 || stream.char_out !== 8'h61) begin
      failures++;
      $display("FAIL a1_first: got valid=%b out=%h, expected 1 61", stream.char_valid, stream.char_out);
    end
    tick();
    checks++;
    if (stream.char_valid !== 1'b1 || stream.char_out !== 8'h31) begin
      failures++;
      $display("FAIL a1_second: got valid=%b out=%h, expected 1 31", stream.char_valid, stream.char_out);
    end
    tick();
    checks++;
    if (stream.char_valid !== 1'b1 || stream.char_out !== 8'h20) begin
      failures++;
      $display("FAIL a1_term: got valid=%b out=%h, expected 1 20", stream.char_valid, stream.char_out);
    end
    tick();
    checks++;
    if (done !== 1'b1 || stream.char_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL a1_done: got done=%b valid=%b busy=%b, expected 1 0 1", done, stream.char_valid, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL a1_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL a1_leftover: got %0d unsent chars, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_ready_toggle();
    logic [7:0] po;
    logic       pv;
    logic       r;
    do_clear();
    load_char(8'h41);
    load_char(8'h62);
    load_char(8'h39);
    stream.char_ready = 1'b1;
    do_start();
    r = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) break;
      stream.char_ready = r;
      pv = stream.char_valid;
      po = stream.char_out;
      tick();
      if (pv === 1'b1 && r == 1'b0) begin
        checks++;
        if (stream.char_valid !== 1'b1 || stream.char_out !== po) begin
          failures++;
          $display("FAIL toggle_hold: got valid=%b out=%h, expected 1 %h", stream.char_valid, stream.char_out, po);
        end
      end
      r = ~r;
    end
    wait_done(4);
    stream.char_ready = 1'b1;
  endtask

  task automatic test_overflow();
    do_clear();
    stream.char_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) load_char(8'($urandom_range(33, 126)));
    checks++;
    if (len !== 5'd16 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL full_no_ovf: got len=%0d ovf=%b, expected 16 0", len, overflow);
    end
    load_char(8'($urandom_range(33, 126)));
    checks++;
    if (len !== 5'd16 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got len=%0d ovf=%b, expected 16 1", len, overflow);
    end
    do_start();
    wait_done(40);
    checks++;
    if (overflow !== 1'b1 || len !== 5'd16) begin
      failures++;
      $display("FAIL ovf_sticky: got len=%0d ovf=%b, expected 16 1", len, overflow);
    end
    do_clear();
    checks++;
    if (len !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got len=%0d ovf=%b, expected 0 0", len, overflow);
    end
  endtask

  task automatic test_empty_start();
    do_clear();
    stream.char_ready = 1'b1;
    do_start();
    checks++;
    if (stream.char_valid !== 1'b1 || stream.char_out !== 8'h20 || state_dbg !== TAIL) begin
      failures++;
      $display("FAIL empty_term: got valid=%b out=%h state=%0d, expected 1 20 2",
               stream.char_valid, stream.char_out, state_dbg);
    end
    tick();
    checks++;
    if (done !== 1'b1 || stream.char_valid !== 1'b0) begin
      failures++;
      $display("FAIL empty_done: got done=%b valid=%b, expected 1 0", done, stream.char_valid);
    end
    wait_done(2);
  endtask

  task automatic test_reset_mid_send();
    int d0;
    do_clear();
    load_char(8'h78);
    load_char(8'h79);
    load_char(8'h7A);
    stream.char_ready = 1'b1;
    d0 = done_cnt;
    do_start();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (stream.char_valid !== 1'b0 || len !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: got valid=%b len=%0d busy=%b, expected 0 0 0", stream.char_valid, len, busy);
    end
    exp_q.delete();
    model_buf.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL rst_release: got busy=%b done_pulses=%0d, expected 0 %0d", busy, done_cnt, d0);
    end
  endtask

  task automatic test_ignore_in_send();
    do_clear();
    load_char(8'h68);
    load_char(8'h69);
    stream.char_ready = 1'b0;
    do_start();
    for (int i = 0; i < 2; i++) begin
      wr_en   = 1'b1;
      wr_char = 8'h7A;
      clear   = 1'b1;
      start   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    checks++;
    if (len !== 5'd2 || state_dbg !== SEND || stream.char_out !== 8'h68) begin
      failures++;
      $display("FAIL ignore_cmds: got len=%0d state=%0d out=%h, expected 2 1 68", len, state_dbg, stream.char_out);
    end
    stream.char_ready = 1'b1;
    wait_done(10);
    do_start();
    wait_done(10);
    checks++;
    if (len !== 5'd2 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL resend_len: got len=%0d ovf=%b, expected 2 0", len, overflow);
    end
  endtask

  // Test sequence and final report
  initial begin
    stream.char_ready = 1'b0;
    test_reset();
    test_basic_a1();
    test_ready_toggle();
    test_overflow();
    test_empty_start();
    test_reset_mid_send();
    test_ignore_in_send();
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_char_tx.md
Name: id_char_tx

Overview:
- Character-stream transmitter that feeds the identifier-recognition path, one 8-bit ASCII character per accepted beat.
- Host loads a string into an internal buffer, then pulses start.
- Block emits the buffered characters in order under a valid/ready handshake, followed by one terminator character.
- Used as the stimulus/source end of the char-by-char identifier checker interface, in benches and in the pre-lab top level.

Parameters:
DEPTH  16     buffer capacity in characters (power of 2, >=2)
TERM   8'h20  terminator character appended after the buffered string (space)
LW     5      width of len; must satisfy 2**LW > DEPTH

Ports:
clk         in   1       clock, rising edge
rst_n       in   1       asynchronous active-low reset
wr_en       in   1       write wr_char at buffer[len] (IDLE only)
wr_char     in   8       character to load
clear       in   1       empty the buffer (IDLE only)
start       in   1       begin transmission (IDLE only)
char_out    out  8       current character; 8'h00 when char_valid=0
char_valid  out  1       char_out holds a character
char_ready  in   1       sink accepts char_out this cycle
busy        out  1       state != IDLE
done        out  1       one-cycle pulse after the terminator is accepted
len         out  LW      number of characters loaded
overflow    out  1       sticky: a write was attempted while len==DEPTH

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, len=0, idx=0, overflow=0, char_valid=0, char_out=8'h00, done=0, busy=0. Buffer contents are not reset and are don't-care.
- FSM states: IDLE, SEND, TAIL, FIN.
- IDLE, priority order per cycle is clear > start > wr_en:
  - clear: len<=0, overflow<=0.
  - else start with len>0: idx<=0, go to SEND.
  - else start with len==0: go to TAIL (terminator only).
  - else wr_en with len<DEPTH: buf[len]<=wr_char, len<=len+1.
  - else wr_en with len==DEPTH: write dropped, overflow<=1.
- SEND:
  - char_valid=1, char_out=buf[idx].
  - On char_ready: if idx==len-1 go to TAIL, else idx<=idx+1.
  - Without char_ready: char_out and char_valid are held stable, with no change until accepted.
- TAIL:
  - char_valid=1, char_out=TERM.
  - On char_ready: go to FIN.
- FIN: char_valid=0, done=1 for exactly this cycle, then IDLE unconditionally.
- Timing:
  - First character is valid the cycle after start is sampled.
  - With char_ready held high, a string of n characters occupies n+1 consecutive valid cycles, then the done cycle.
- Buffer and len are retained after FIN, so a second start resends the same string.
- In SEND/TAIL/FIN, wr_en, clear and start are ignored. len and overflow are frozen.
- Outputs char_out/char_valid/done/busy are decoded from registered state only, with no combinational path from char_ready or any other input.
- Reset asserted mid-stream: immediate return to reset values, char_valid drops asynchronously, no done pulse.
- idx width is LW. Comparisons use len-1, only evaluated when len>0.

Decomposition:
- Shared package id_pkg holds:
  - state encoding (IDLE=2'b00, SEND=2'b01, TAIL=2'b10, FIN=2'b11);
  - ASCII class constants shared with the recognizer (DIGIT_LO=8'd48, DIGIT_HI=8'd57, UPPER 65-90, LOWER 97-122);
  - default TERM.
- Natural sub-module: id_char_buf, a DEPTH x 8 register file with synchronous write port and combinational read port. The FSM and counters stay in id_char_tx.

Test Plan:
- Load "a1" (8'h61, 8'h31), start, char_ready=1 constantly -> char_out sequence 61, 31, 20 on three consecutive valid cycles. done=1 on the 4th cycle, busy=0 on the 5th.
- Load "Ab9", start, char_ready toggling 1,0,1,0 -> each character is held while ready=0. Sink receives exactly 41, 62, 39, 20 with no duplicates.
- Write 17 characters with DEPTH=16 -> len=16, overflow=1. Then clear -> len=0, overflow=0.
- start with len=0 -> single valid beat of 8'h20, then done pulse.
- Mid-SEND (after first character accepted) pull rst_n low -> char_valid=0 and len=0 in the same cycle, done never asserts. After release, busy=0.
- During SEND, assert wr_en with 8'h7A and clear -> ignored. len unchanged, and a subsequent restart resends the original string.
